// File: rtl/r_diag_serial.sv
// Serial generator for the diagonal of the measurement-noise covariance R, one channel per clock.
// Optional R_FLOOR_EN clamps every diagonal entry to at least R_MIN.

`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif

module r_diag_serial #(
    parameter int                    N     = `FXP_N,
    parameter int                    FRAC  = `FXP_FRAC,
    parameter int                    M     = 2,
    parameter logic signed [N-1:0]   R_MIN = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   beta,
    input  logic [M*N-1:0] sigma_a_flat,
    input  logic [M*N-1:0] sigma_b_flat,
    input  logic [M*N-1:0] z_flat,
    input  logic [M*N-1:0] zhat_flat,
    output logic           busy,
    output logic           done,
    output logic [M*N-1:0] R_diag_flat
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic [IW-1:0]         r_idx;
    logic                  r_busy;
    logic                  r_done;
    logic [M*N-1:0]        r_rdiag;
    logic signed [N-1:0]   r_beta;
    logic signed [N-1:0]   r_sa [M];
    logic signed [N-1:0]   r_sb [M];
    logic signed [N-1:0]   r_z  [M];
    logic signed [N-1:0]   r_zh [M];
    logic [N-1:0]          r_w  [M];

    logic                  w_accept;
    logic                  w_last;
    logic signed [N-1:0]   w_pa;
    logic signed [N-1:0]   w_pb;
    logic signed [N-1:0]   w_l;
    logic signed [N-1:0]   w_r;
    logic signed [N-1:0]   w_d;
    logic signed [N-1:0]   w_abs;
    logic signed [N-1:0]   w_res;

    // Fixed-point multiply: full 2N-bit product, arithmetic shift, wrap to N bits.
    function automatic logic signed [N-1:0] mul_q(input logic signed [N-1:0] a,
                                                   input logic signed [N-1:0] b);
        logic signed [2*N-1:0] ax;
        logic signed [2*N-1:0] bx;
        logic signed [2*N-1:0] p;
        ax = (2*N)'(a);
        bx = (2*N)'(b);
        p  = (ax * bx) >>> FRAC;
        return p[N-1:0];
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_last     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (r_idx == IW'(M - 1)) begin
                    w_last     = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_pa  = mul_q(r_beta, r_sa[r_idx]);
        w_pb  = mul_q(r_beta, r_sb[r_idx]);
        w_l   = mul_q(w_pa, r_z[r_idx]);
        w_r   = mul_q(w_pb, r_zh[r_idx]);
        w_d   = w_l - w_r;
        // The most-negative difference has no positive twin; pin it to the largest positive value.
        if (w_d == {1'b1, {(N-1){1'b0}}})
            w_abs = {1'b0, {(N-1){1'b1}}};
        else if (w_d[N-1])
            w_abs = -w_d;
        else
            w_abs = w_d;
`ifdef R_FLOOR_EN
        w_res = (w_abs < R_MIN) ? R_MIN : w_abs;
`else
        w_res = w_abs;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdiag <= '0;
            r_beta  <= '0;
            for (int unsigned k = 0; k < M; k++) begin
                r_sa[k] <= '0;
                r_sb[k] <= '0;
                r_z[k]  <= '0;
                r_zh[k] <= '0;
                r_w[k]  <= '0;
            end
        end else begin
            r_state <= w_state_nx;
            r_done  <= w_last;
            if (w_accept) begin
                r_idx  <= '0;
                r_busy <= 1'b1;
                r_beta <= beta;
                for (int unsigned k = 0; k < M; k++) begin
                    r_sa[k] <= sigma_a_flat[k*N +: N];
                    r_sb[k] <= sigma_b_flat[k*N +: N];
                    r_z[k]  <= z_flat[k*N +: N];
                    r_zh[k] <= zhat_flat[k*N +: N];
                end
            end
            if (r_state == S_RUN) begin
                r_w[r_idx] <= w_res;
                if (w_last) begin
                    r_idx  <= '0;
                    r_busy <= 1'b0;
                    // Commit bypasses W for the final channel, which is written on this same edge.
                    for (int unsigned k = 0; k < M; k++)
                        r_rdiag[k*N +: N] <= (IW'(k) == r_idx) ? w_res : r_w[k];
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign R_diag_flat = r_rdiag;

endmodule

// File: tb/tb_r_diag_serial.sv
// Directed bench for r_diag_serial (M=3 and M=1 instances) with a per-cycle reference model.
module tb_r_diag_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start3 = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] beta3 = '0, beta1 = '0;
    logic [47:0] sa3 = '0, sb3 = '0, z3 = '0, zh3 = '0;
    logic [15:0] sa1 = '0, sb1 = '0, z1 = '0, zh1 = '0;
    logic        busy3, done3, busy1, done1;
    logic [47:0] rd3;
    logic [15:0] rd1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    r_diag_serial #(.N(16), .FRAC(8), .M(3), .R_MIN(16'sh0010)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .beta(beta3),
        .sigma_a_flat(sa3), .sigma_b_flat(sb3), .z_flat(z3), .zhat_flat(zh3),
        .busy(busy3), .done(done3), .R_diag_flat(rd3));

    r_diag_serial #(.N(16), .FRAC(8), .M(1), .R_MIN(16'sh0010)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .beta(beta1),
        .sigma_a_flat(sa1), .sigma_b_flat(sb1), .z_flat(z1), .zhat_flat(zh1),
        .busy(busy1), .done(done1), .R_diag_flat(rd1));

    function automatic int q_mul(input int a, input int b);
        return int'(shortint'((a * b) >>> 8));
    endfunction

    function automatic logic [15:0] rchan(input logic [15:0] b, input logic [15:0] sa,
                                         input logic [15:0] sb, input logic [15:0] z,
                                         input logic [15:0] zh);
        int l, r, d, res;
        l = q_mul(q_mul(int'($signed(b)), int'($signed(sa))), int'($signed(z)));
        r = q_mul(q_mul(int'($signed(b)), int'($signed(sb))), int'($signed(zh)));
        d = int'(shortint'(l - r));
        if (d == -32768) res = 32767;
        else res = (d < 0) ? -d : d;
`ifdef R_FLOOR_EN
        if (res < 16) res = 16;
`endif
        return 16'(res);
    endfunction

    function automatic logic [47:0] rvec(input logic [15:0] b, input logic [47:0] sa,
                                         input logic [47:0] sb, input logic [47:0] z,
                                         input logic [47:0] zh, input int m);
        logic [47:0] v;
        v = '0;
        for (int k = 0; k < m; k++)
            v[k*16 +: 16] = rchan(b, sa[k*16 +: 16], sb[k*16 +: 16], z[k*16 +: 16], zh[k*16 +: 16]);
        return v;
    endfunction

    // Reference: a run finishes m clocks after acceptance; outputs only move at that point.
    logic        m_busy3, m_done3, m_busy1, m_done1;
    int          m_cnt3, m_cnt1;
    logic [47:0] m_pend3, m_r3;
    logic [15:0] m_pend1, m_r1;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy3 <= 1'b0; m_done3 <= 1'b0; m_cnt3 <= 0; m_r3 <= '0; m_pend3 <= '0;
            m_busy1 <= 1'b0; m_done1 <= 1'b0; m_cnt1 <= 0; m_r1 <= '0; m_pend1 <= '0;
        end else begin
            m_done3 <= 1'b0;
            if (!m_busy3 && start3) begin
                m_busy3 <= 1'b1; m_cnt3 <= 3;
                m_pend3 <= rvec(beta3, sa3, sb3, z3, zh3, 3);
            end else if (m_busy3) begin
                if (m_cnt3 == 1) begin
                    m_busy3 <= 1'b0; m_done3 <= 1'b1; m_r3 <= m_pend3;
                end
                m_cnt3 <= m_cnt3 - 1;
            end
            m_done1 <= 1'b0;
            if (!m_busy1 && start1) begin
                m_busy1 <= 1'b1; m_cnt1 <= 1;
                m_pend1 <= rchan(beta1, sa1, sb1, z1, zh1);
            end else if (m_busy1) begin
                if (m_cnt1 == 1) begin
                    m_busy1 <= 1'b0; m_done1 <= 1'b1; m_r1 <= m_pend1;
                end
                m_cnt1 <= m_cnt1 - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy3", 64'(busy3), 64'(m_busy3));
            chk("done3", 64'(done3), 64'(m_done3));
            chk("rdiag3", 64'(rd3), 64'(m_r3));
            chk("busy1", 64'(busy1), 64'(m_busy1));
            chk("done1", 64'(done1), 64'(m_done1));
            chk("rdiag1", 64'(rd1), 64'(m_r1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit one, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(one ? done1 : done3) && cyc < 20);
        if (!(one ? done1 : done3)) begin
            errors++;
            $display("FAIL done_timeout actual=none required=done within 20 cycles");
        end
    endtask

`ifdef R_FLOOR_EN
    localparam logic [15:0] ZERO_R = 16'h0010;
`else
    localparam logic [15:0] ZERO_R = 16'h0000;
`endif

    task automatic load_basic();
        beta3 = 16'h0100;
        sa3 = {16'h0100, 16'h0100, 16'h0200};
        z3  = {16'h0100, 16'h0100, 16'h0180};
        sb3 = {16'h0100, 16'h0200, 16'h0100};
        zh3 = {16'h0100, 16'h0180, 16'h0100};
    endtask

    logic [47:0] exp_v;
    int cyc;
    int busy_cnt;
    bit saw_done;

    initial begin
        tick();
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_rdiag", 64'(rd3), 64'h0);
        chk("reset_busy", 64'(busy3), 64'h0);
        rst_n = 1'b1;
        tick();

        // Basic + sign cases
        load_basic();
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        busy_cnt = 0;
        cyc = 0;
        do begin
            if (busy3) busy_cnt++;
            tick();
            cyc++;
        end while (!done3 && cyc < 20);
        chk("basic_latency", 64'(cyc), 64'd3);
        chk("basic_busy_cycles", 64'(busy_cnt), 64'd3);
        exp_v = {ZERO_R, 16'h0200, 16'h0200};
        chk("basic_rdiag", 64'(rd3), 64'(exp_v));
        tick();
        chk("done_pulse_width", 64'(done3), 64'h0);

        // Snapshot: alter inputs after accept, restart while busy
        sa3 = {16'h0100, 16'h0080, 16'h0200};
        z3  = {16'h0100, 16'hFF00, 16'h0280};
        sb3 = {16'h0100, 16'h0000, 16'h0100};
        zh3 = {16'h0300, 16'h0000, 16'h0100};
        start3 = 1'b1;
        tick();
        z3 = '0;
        tick();
        start3 = 1'b0;
        chk("snap_hold", 64'(rd3), 64'(exp_v));
        wait_done(1'b0, cyc);
        chk("snap_latency", 64'(cyc), 64'd2);
        chk("snap_rdiag", 64'(rd3), 64'h0000_0200_0080_0400);

        // Back-to-back: start in the done cycle
        beta3 = 16'h0200;
        sa3 = {16'h0100, 16'h0100, 16'h0100};
        z3  = {16'h0300, 16'h0200, 16'h0100};
        sb3 = '0;
        zh3 = '0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("b2b_hold", 64'(rd3), 64'h0000_0200_0080_0400);
        wait_done(1'b0, cyc);
        chk("b2b_latency", 64'(cyc), 64'd3);
        chk("b2b_rdiag", 64'(rd3), 64'h0000_0600_0400_0200);
        tick();

        // Reset mid-run at idx=1
        load_basic();
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midreset_rdiag", 64'(rd3), 64'h0);
        chk("midreset_busy", 64'(busy3), 64'h0);
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done3) saw_done = 1'b1;
        end
        chk("midreset_no_done", 64'(saw_done), 64'h0);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        wait_done(1'b0, cyc);
        chk("after_reset_latency", 64'(cyc), 64'd3);
        chk("after_reset_rdiag", 64'(rd3), 64'({ZERO_R, 16'h0200, 16'h0200}));
        tick();

        // Saturating abs: L = -32768, R = 0
        beta3 = 16'h0100;
        sa3 = {16'h0000, 16'h0000, 16'h8000};
        z3  = {16'h0000, 16'h0000, 16'h0100};
        sb3 = '0;
        zh3 = '0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        wait_done(1'b0, cyc);
        chk("sat_rdiag", 64'(rd3), 64'({ZERO_R, ZERO_R, 16'h7FFF}));

        beta1 = 16'h0100;
        sa1 = 16'h8000;
        z1  = 16'h0100;
        sb1 = 16'h0000;
        zh1 = 16'h0000;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("m1_busy", 64'(busy1), 64'h1);
        wait_done(1'b1, cyc);
        chk("m1_latency", 64'(cyc), 64'd1);
        chk("m1_rdiag", 64'(rd1), 64'h7FFF);
        tick();
        chk("m1_idle", 64'(busy1), 64'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
